// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory-side responder.
// The INIT state exists only when SRAM_INIT_EN is defined.
package slc3_mem_pkg;

    localparam int SLC3_WORD_W       = 16;
    localparam int SLC3_READ_LAT_DEF = 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RD_WAIT = 2'd1,
`ifdef SRAM_INIT_EN
        S_RD_OUT  = 2'd2,
        S_INIT    = 2'd3
`else
        S_RD_OUT  = 2'd2
`endif
    } sram_resp_state_t;

endpackage

// File: rtl/mem_init_rom.sv
// Combinational boot image for the SLC-3 array, copied in word by word by the
// responder's INIT walk (used only when SRAM_INIT_EN is defined).
module mem_init_rom
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic [ADDR_W-1:0]      addr_i,
    output logic [SLC3_WORD_W-1:0] data_o
);

    // Tiny counting loop: AND R0,R0,#0 / ADD R0,R0,#1 / BRnzp -2 / HALT; rest NOP.
    always_comb begin
        data_o = 16'h0000;
        case (addr_i)
            ADDR_W'(0): data_o = 16'h5020;
            ADDR_W'(1): data_o = 16'h1021;
            ADDR_W'(2): data_o = 16'h0FFE;
            ADDR_W'(3): data_o = 16'hF025;
            default:    data_o = 16'h0000;
        endcase
    end

endmodule

// File: rtl/sram_responder.sv
// On-chip SRAM stand-in for the SLC-3 MAR/MDR interface: zero-wait writes,
// fixed-latency registered reads. Optional boot-image load under SRAM_INIT_EN.
module sram_responder
    import slc3_mem_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int READ_LAT = SLC3_READ_LAT_DEF
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [15:0]            ADDR,
    input  logic [15:0]            Data_to_SRAM,
    input  logic                   OE,
    input  logic                   WE,
    output logic [15:0]            Data_from_SRAM,
    output logic                   rd_valid,
    output logic                   busy,
    output sram_resp_state_t       dbg_state
);

    localparam int CNT_W = 3;
    localparam int DEPTH = 2 ** ADDR_W;

    sram_resp_state_t          state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]         addr_q, addr_d;
    logic [SLC3_WORD_W-1:0]    dout_q;
    logic                      valid_q;
    logic                      rd_fire;
    logic                      wr_en;
    logic [ADDR_W-1:0]         wr_addr;
    logic [SLC3_WORD_W-1:0]    wr_data;
    logic [SLC3_WORD_W-1:0]    mem_q [DEPTH];
    logic                      unused_addr_bits;

    assign unused_addr_bits = ^ADDR;

`ifdef SRAM_INIT_EN
    logic [ADDR_W-1:0]      init_addr_q, init_addr_d;
    logic [SLC3_WORD_W-1:0] rom_data;

    mem_init_rom #(.ADDR_W(ADDR_W)) u_rom (
        .addr_i (init_addr_q),
        .data_o (rom_data)
    );
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
`ifdef SRAM_INIT_EN
            state_q     <= S_INIT;
            init_addr_q <= '0;
`else
            state_q     <= S_IDLE;
`endif
            cnt_q       <= '0;
            addr_q      <= '0;
        end else begin
`ifdef SRAM_INIT_EN
            init_addr_q <= init_addr_d;
`endif
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
        end
    end

    // RD_OUT is the edge that samples the array. A back-to-back launch from
    // RD_OUT reloads one extra count, so held-OE reads repeat every READ_LAT+1.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rd_fire = 1'b0;
`ifdef SRAM_INIT_EN
        init_addr_d = init_addr_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!OE && WE) begin
                    addr_d  = ADDR[ADDR_W-1:0];
                    cnt_d   = CNT_W'(READ_LAT - 1);
                    state_d = (READ_LAT == 1) ? S_RD_OUT : S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = S_RD_OUT;
                end
            end
            S_RD_OUT: begin
                rd_fire = 1'b1;
                if (!OE && WE) begin
                    addr_d  = ADDR[ADDR_W-1:0];
                    cnt_d   = CNT_W'(READ_LAT);
                    state_d = S_RD_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
`ifdef SRAM_INIT_EN
            S_INIT: begin
                init_addr_d = init_addr_q + ADDR_W'(1);
                if (init_addr_q == '1) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        wr_en   = !WE;
        wr_addr = ADDR[ADDR_W-1:0];
        wr_data = Data_to_SRAM;
`ifdef SRAM_INIT_EN
        if (state_q == S_INIT) begin
            wr_en   = 1'b1;
            wr_addr = init_addr_q;
            wr_data = rom_data;
        end
`endif
    end

    // Array has no reset: contents survive Reset and start undefined.
    always_ff @(posedge Clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            dout_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_fire;
            if (rd_fire) begin
                dout_q <= mem_q[addr_q];
            end
        end
    end

    assign Data_from_SRAM = dout_q;
    assign rd_valid       = valid_q;
    assign busy           = (state_q != S_IDLE);
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_sram_responder.sv
// Self-checking bench for sram_responder; build with +define+SRAM_INIT_EN to
// exercise the boot-image load (array shrinks to 16 words in that build).
module tb_sram_responder;
    import slc3_mem_pkg::*;

    localparam int LAT = 2;
`ifdef SRAM_INIT_EN
    localparam int AW = 4;
    localparam logic BUSY_RST = 1'b1;
`else
    localparam int AW = 10;
    localparam logic BUSY_RST = 1'b0;
`endif

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [15:0]      ADDR = '0;
    logic [15:0]      Data_to_SRAM = '0;
    logic             OE = 1'b1;
    logic             WE = 1'b1;
    logic [15:0]      Data_from_SRAM;
    logic             rd_valid;
    logic             busy;
    sram_resp_state_t dbg_state;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    logic [15:0] exp_q[$];
    logic [15:0] model_mem [2**AW];

    sram_responder #(.ADDR_W(AW), .READ_LAT(LAT)) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .ADDR           (ADDR),
        .Data_to_SRAM   (Data_to_SRAM),
        .OE             (OE),
        .WE             (WE),
        .Data_from_SRAM (Data_from_SRAM),
        .rd_valid       (rd_valid),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every rd_valid pulse must match the oldest expected word.
    always @(posedge Clk) begin
        #1;
        if (rd_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) check("unexpected_rd_valid", {31'b0, rd_valid}, 32'd0);
            else check("rd_data", {16'b0, Data_from_SRAM}, {16'b0, exp_q.pop_front()});
        end
    end

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        @(negedge Clk);
        ADDR = a; Data_to_SRAM = d; WE = 1'b0; OE = 1'b1;
        @(negedge Clk);
        WE = 1'b1;
        model_mem[a[AW-1:0]] = d;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] exp);
        int lat;
        int busy_cycles;
        bit seen;
        @(negedge Clk);
        ADDR = a; OE = 1'b0; WE = 1'b1;
        exp_q.push_back(exp);
        @(posedge Clk); #1;
        busy_cycles = busy ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        @(negedge Clk);
        OE = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge Clk); #1;
            lat++;
            if (rd_valid) seen = 1'b1;
            else if (busy) busy_cycles++;
        end
        check("rd_seen", {31'b0, seen}, 32'd1);
        check("rd_latency", lat, LAT);
        check("rd_busy_cycles", busy_cycles, LAT);
        check("busy_after_rd", {31'b0, busy}, 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge Clk);
        check(tag, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int v0;
        int n;
        int e1;
        int e2;
        for (int i = 0; i < 2**AW; i++) model_mem[i] = 16'h0000;

        repeat (3) @(negedge Clk);
        check("rst_dout", {16'b0, Data_from_SRAM}, 32'd0);
        check("rst_valid", {31'b0, rd_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, {31'b0, BUSY_RST});
        Reset = 1'b0;

`ifdef SRAM_INIT_EN
        model_mem[0] = 16'h5020; model_mem[1] = 16'h1021;
        model_mem[2] = 16'h0FFE; model_mem[3] = 16'hF025;
        OE = 1'b0;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge Clk); #1;
            n++;
            if (!busy) break;
        end
        OE = 1'b1;
        check("init_busy_edges", n, 2**AW);
        check("init_oe_ignored", valid_cnt, 0);
        rd(16'h0003, 16'hF025);
`endif

        wr(16'h0010, 16'hBEEF);
        rd(16'h0010, 16'hBEEF);

        wr(16'h0005, 16'h1234);
        rd(16'(32'h5 + (32'h1 << AW)), 16'h1234);

        v0 = valid_cnt;
        @(negedge Clk);
        ADDR = 16'h0020; Data_to_SRAM = 16'hAAAA; OE = 1'b0; WE = 1'b0;
        @(negedge Clk);
        OE = 1'b1; WE = 1'b1;
        model_mem[16'h0020] = 16'hAAAA;
        check("simul_busy", {31'b0, busy}, 32'd0);
        repeat (4) @(negedge Clk);
        check("simul_no_valid", valid_cnt, v0);
        rd(16'h0020, 16'hAAAA);

        wr(16'h0030, 16'h0001);
        exp_q.push_back(16'h0002);
        @(negedge Clk);
        ADDR = 16'h0030; OE = 1'b0;
        @(negedge Clk);
        OE = 1'b1; WE = 1'b0; Data_to_SRAM = 16'h0002;
        @(negedge Clk);
        WE = 1'b1;
        model_mem[16'h0030] = 16'h0002;
        wait_drain("inflight_drained");

        wr(16'h0040, 16'h1111);
        wr(16'h0041, 16'h2222);
        exp_q.push_back(16'h1111);
        exp_q.push_back(16'h2222);
        @(negedge Clk);
        ADDR = 16'h0040; OE = 1'b0;
        @(negedge Clk);
        ADDR = 16'h0041;
        n = 0; e1 = 0; e2 = 0;
        for (int e = 1; e < 20 && n < 2; e++) begin
            @(posedge Clk); #1;
            if (rd_valid) begin
                if (n == 0) e1 = e; else e2 = e;
                n++;
                if (n == 1) begin
                    @(negedge Clk);
                    OE = 1'b1;
                end
            end
        end
        OE = 1'b1;
        check("b2b_count", n, 2);
        check("b2b_first_lat", e1, LAT);
        check("b2b_gap", e2 - e1, LAT + 1);
        wait_drain("b2b_drained");

        for (int i = 0; i < 8; i++) wr(16'(16'h0050 + i), 16'($urandom));
        for (int i = 0; i < 12; i++) begin
            logic [15:0] a;
            a = 16'($urandom_range(16'h0050, 16'h0057));
            if ($urandom_range(0, 1) == 0) wr(a, 16'($urandom));
            else rd(a, model_mem[a[AW-1:0]]);
        end

        v0 = valid_cnt;
        @(negedge Clk);
        ADDR = 16'h0010; OE = 1'b0;
        @(negedge Clk);
        OE = 1'b1;
        check("mr_in_wait", {31'b0, busy}, 32'd1);
        Reset = 1'b1;
        #1;
        check("mr_dout", {16'b0, Data_from_SRAM}, 32'd0);
        check("mr_valid", {31'b0, rd_valid}, 32'd0);
        check("mr_busy", {31'b0, busy}, {31'b0, BUSY_RST});
        @(negedge Clk);
        Reset = 1'b0;
`ifdef SRAM_INIT_EN
        for (int i = 0; i < 100 && busy; i++) @(negedge Clk);
        check("mr_init_done", {31'b0, busy}, 32'd0);
        check("mr_no_valid", valid_cnt, v0);
        rd(16'h0003, 16'hF025);
`else
        repeat (4) @(negedge Clk);
        check("mr_no_valid", valid_cnt, v0);
        rd(16'h0010, 16'hBEEF);
`endif

        repeat (3) @(negedge Clk);
        check("exp_q_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sram_responder.md
# sram_responder

Memory-side responder for the SLC-3 CPU's MAR/MDR memory interface. It takes the CPU's address, write data and active-low OE/WE strobes and serves them from an on-chip word array. Reads return data after a fixed, parameterised latency that matches the ISDU's memory wait states. It sits where the physical SRAM sits, underneath the memory/IO controller, and is the target end of the same `ADDR`/`Data_to_SRAM`/`Data_from_SRAM`/`OE`/`WE` interface.

## Interface
- `ADDR_W`, default 10: array depth is 2^ADDR_W words of 16 bits. Range 4..16.
- `READ_LAT`, default 2: number of edges from a read launch to `Data_from_SRAM` being valid. Range 1..4.
- `Clk` input 1: single clock, rising edge.
- `Reset` input 1: asynchronous, active-high reset.
- `ADDR` input 16: word address; only bits [ADDR_W-1:0] are used, so upper bits alias (wrap).
- `Data_to_SRAM` input 16: write data.
- `OE` input 1: active-low read strobe.
- `WE` input 1: active-low write strobe.
- `Data_from_SRAM` output 16: read data, held until the next read completes.
- `rd_valid` output 1: one-cycle pulse when new read data is driven.
- `busy` output 1: high in any state other than IDLE.

## Operation
- States: IDLE, RD_WAIT, RD_OUT, plus INIT when `SRAM_INIT_EN` is defined.
- IDLE
  - WE=0 at an edge: write `Data_to_SRAM` to `mem[ADDR[ADDR_W-1:0]]`. Stay in IDLE.
  - OE=0 and WE=1: latch the address, load the latency counter with READ_LAT-1, and go to RD_WAIT. If READ_LAT=1, go directly to RD_OUT.
  - OE=0 and WE=0 together: WE wins. The write is performed and no read launches.
- RD_WAIT: the counter decrements each edge. At 0, go to RD_OUT. `ADDR`/`OE` changes here are ignored because the address is latched.
- RD_OUT
  - `Data_from_SRAM` is set to `mem[latched_addr]` as read on this edge, and `rd_valid` pulses.
  - If OE is still 0 with WE=1, launch a new read immediately (back-to-back). Otherwise go to IDLE.
- Writes are accepted in IDLE, RD_WAIT and RD_OUT. A write to the in-flight read address before the RD_OUT edge is returned by that read (new data).
- The array is not cleared by reset. Its contents are undefined unless `SRAM_INIT_EN` is defined.

## Timing
- Reset values: `Data_from_SRAM`=16'h0000, `rd_valid`=0. `busy`=0, or 1 with `SRAM_INIT_EN`. State is IDLE, or INIT with `SRAM_INIT_EN`.
- Read latency: OE sampled low at edge N, data and `rd_valid` registered at edge N+READ_LAT.
- Back-to-back reads with OE held low: one result every READ_LAT+1 edges.
- Writes: commit at the sampling edge, zero wait states. A read launched on the next edge sees the new data.
- Reset asserted mid-read: abort immediately, drive the reset values, and return no data.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `SRAM_INIT_EN`
  - Defined: after reset deassertion, INIT walks addresses 0..2^ADDR_W-1, one word per edge, writing `mem_init_rom` contents. `busy`=1 throughout, and OE/WE are ignored. INIT then goes to IDLE.
  - Undefined: there is no INIT state and no ROM, and the responder is in IDLE from reset.

## Structure
- Shared package `slc3_mem_pkg`:
  - state enum `sram_resp_state_t`
  - `SLC3_WORD_W`=16
  - read-latency default constant
- One sub-module, `mem_init_rom`: combinational address-to-16-bit program image. It is instantiated only under `SRAM_INIT_EN`.
- The array is inferred as a single-port-write, registered-read memory.

## Test plan
- Write, then read at READ_LAT=2: WE=0 with ADDR=16'h0010, data 16'hBEEF; then OE=0 at edge N. Required: `Data_from_SRAM`=16'hBEEF and `rd_valid`=1 at edge N+2, `busy` high for 2 cycles.
- Wrap, ADDR_W=10: write 16'h1234 to 16'h0005, then read 16'h0405. Required: returns 16'h1234.
- Simultaneous strobes: OE=0 and WE=0 at 16'h0020 with data 16'hAAAA. Required: no `rd_valid`; a later read of 16'h0020 returns 16'hAAAA.
- In-flight write: read 16'h0030 (old value 16'h0001), then write 16'h0002 there during RD_WAIT. Required: the read returns 16'h0002.
- Reset mid-read: assert Reset in RD_WAIT. Required: `Data_from_SRAM`=0, `rd_valid` never pulses, `busy` drops, or stays high through INIT with `SRAM_INIT_EN`.
- `SRAM_INIT_EN` defined, ADDR_W=4: release reset. Required: `busy` is high for 16 cycles, OE is ignored during INIT, and a read of address 3 afterwards returns the ROM word 3.
